// File: rtl/attn_value_mac_if.sv
// Start/done handshake and flat operand/result buses of the attention P*V stage.
// The upstream block drives the master side; attn_value_mac takes the slave side.
interface attn_value_mac_if #(
  parameter int SCORE_WIDTH  = 32,
  parameter int VALUE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SEQ_LEN      = 64,
  parameter int HEAD_DIM     = 64
);
  logic                                      start;
  logic [SCORE_WIDTH*SEQ_LEN*SEQ_LEN-1:0]    scores_flat;
  logic [VALUE_WIDTH*SEQ_LEN*HEAD_DIM-1:0]   v_flat;
  logic                                      busy;
  logic                                      done;
  logic [OUTPUT_WIDTH*SEQ_LEN*HEAD_DIM-1:0]  out_flat;

  modport master (
    output start, scores_flat, v_flat,
    input  busy, done, out_flat
  );

  modport slave (
    input  start, scores_flat, v_flat,
    output busy, done, out_flat
  );
endinterface

// File: rtl/attn_value_mac.sv
// Single-MAC sequential engine computing O = P*V for one attention head.
// Optional build macro AV_ROUND_EN: round-half-up before the output shift (default truncates).
module attn_value_mac #(
  parameter int SCORE_WIDTH  = 32,
  parameter int VALUE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SEQ_LEN      = 64,
  parameter int HEAD_DIM     = 64,
  parameter int FRAC_BITS    = 14
) (
  input logic              clk,
  input logic              rst,
  attn_value_mac_if.slave  bus
);

  localparam int IW   = $clog2(SEQ_LEN);
  localparam int DW   = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
  localparam int PW   = SCORE_WIDTH + VALUE_WIDTH + 1;
  localparam int AW   = SCORE_WIDTH + VALUE_WIDTH + IW + 1;
  localparam int NOUT = SEQ_LEN * HEAD_DIM;
  localparam int OIW  = $clog2(NOUT);
  localparam int PBW  = $clog2(SCORE_WIDTH * SEQ_LEN * SEQ_LEN);
  localparam int VBW  = $clog2(VALUE_WIDTH * SEQ_LEN * HEAD_DIM);

  localparam logic signed [AW-1:0] O_MAX =
    {{(AW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] O_MIN =
    {{(AW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           i_q, k_q;
  logic [DW-1:0]           d_q;
  logic signed [AW-1:0]    acc_q;
  logic                    done_q;
  logic [OUTPUT_WIDTH-1:0] o_mem [NOUT];

  logic last_k, last_d, last_elem;
  assign last_k    = (k_q == IW'(SEQ_LEN - 1));
  assign last_d    = (d_q == DW'(HEAD_DIM - 1));
  assign last_elem = last_d && (i_q == IW'(SEQ_LEN - 1));

  // Operand fetch straight from the held input buses; nothing is captured.
  logic [PBW-1:0]         p_off;
  logic [VBW-1:0]         v_off;
  logic [OIW-1:0]         w_idx;
  logic [SCORE_WIDTH-1:0] p_elem;
  logic [VALUE_WIDTH-1:0] v_elem;

  assign p_off  = PBW'((int'(i_q) * SEQ_LEN + int'(k_q)) * SCORE_WIDTH);
  assign v_off  = VBW'((int'(k_q) * HEAD_DIM + int'(d_q)) * VALUE_WIDTH);
  assign w_idx  = OIW'(int'(i_q) * HEAD_DIM + int'(d_q));
  assign p_elem = bus.scores_flat[p_off +: SCORE_WIDTH];
  assign v_elem = bus.v_flat[v_off +: VALUE_WIDTH];

  logic signed [PW-1:0] p_ext, v_ext, prod;
  logic signed [AW-1:0] acc_sum;

  assign p_ext   = {{(PW-SCORE_WIDTH){1'b0}}, p_elem};
  assign v_ext   = {{(PW-VALUE_WIDTH){v_elem[VALUE_WIDTH-1]}}, v_elem};
  assign prod    = p_ext * v_ext;
  assign acc_sum = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

  // Requantise the finished dot product back to Q(FRAC_BITS) with clamping.
  logic signed [AW-1:0]    acc_adj, shifted;
  logic [OUTPUT_WIDTH-1:0] sat_val;

`ifdef AV_ROUND_EN
  localparam logic signed [AW-1:0] HALF_LSB = AW'(1) << (FRAC_BITS - 1);
  assign acc_adj = acc_q + HALF_LSB;
`else
  assign acc_adj = acc_q;
`endif

  assign shifted = acc_adj >>> FRAC_BITS;

  // NOTE: every path assigns sat_val, so this block stays combinational with no latch.
  always_comb begin
    if (shifted > O_MAX)      sat_val = O_MAX[OUTPUT_WIDTH-1:0];
    else if (shifted < O_MIN) sat_val = O_MIN[OUTPUT_WIDTH-1:0];
    else                      sat_val = shifted[OUTPUT_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (last_k)    state_d = WRITE;
      WRITE:   state_d = last_elem ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q    <= '0;
      d_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            i_q   <= '0;
            d_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_sum;
          if (!last_k) k_q <= k_q + IW'(1);
        end
        WRITE: begin
          acc_q <= '0;
          k_q   <= '0;
          if (last_d) begin
            d_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the result array is reset element-wise so out_flat reads zero after rst;
  // that rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NOUT; n++) o_mem[n] <= '0;
    end else if (state_q == WRITE) begin
      o_mem[w_idx] <= sat_val;
    end
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_pack
    assign bus.out_flat[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] = o_mem[g];
  end

  // busy covers the done cycle even though the FSM is already back in IDLE.
  assign bus.busy = (state_q != IDLE) || done_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_attn_value_mac.sv
// Scoreboard bench for attn_value_mac: a 32-bit-output and a 16-bit-output (saturating)
// instance, checked against a plain-arithmetic matrix product model.
module tb_attn_value_mac;

  localparam int SW  = 32;
  localparam int VW  = 32;
  localparam int SL  = 4;
  localparam int HD  = 2;
  localparam int FB  = 14;
  localparam int OW  = 32;
  localparam int OWS = 16;
  localparam int NE  = SL * HD;
  localparam int N   = SL * HD * (SL + 1);
  localparam int BOUND = 200;

`ifdef AV_ROUND_EN
  localparam longint RND_EXP = 1;
`else
  localparam longint RND_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  attn_value_mac_if #(.SCORE_WIDTH(SW), .VALUE_WIDTH(VW), .OUTPUT_WIDTH(OW),
                      .SEQ_LEN(SL), .HEAD_DIM(HD)) m_if ();
  attn_value_mac_if #(.SCORE_WIDTH(SW), .VALUE_WIDTH(VW), .OUTPUT_WIDTH(OWS),
                      .SEQ_LEN(SL), .HEAD_DIM(HD)) s_if ();

  attn_value_mac #(.SCORE_WIDTH(SW), .VALUE_WIDTH(VW), .OUTPUT_WIDTH(OW),
                   .SEQ_LEN(SL), .HEAD_DIM(HD), .FRAC_BITS(FB))
    dut_main (.clk(clk), .rst(rst), .bus(m_if));

  attn_value_mac #(.SCORE_WIDTH(SW), .VALUE_WIDTH(VW), .OUTPUT_WIDTH(OWS),
                   .SEQ_LEN(SL), .HEAD_DIM(HD), .FRAC_BITS(FB))
    dut_sat (.clk(clk), .rst(rst), .bus(s_if));

  typedef struct {
    longint o [NE];
    int     done_edge;
  } exp_t;

  exp_t   q_main[$];
  exp_t   q_sat[$];
  longint p_m [SL][SL];
  longint v_m [SL][HD];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint m_elem(input int idx);
    return longint'($signed(m_if.out_flat[idx*OW +: OW]));
  endfunction

  function automatic longint s_elem(input int idx);
    return longint'($signed(s_if.out_flat[idx*OWS +: OWS]));
  endfunction

  // Reference: O[i][d] = clamp((sum_k P[i][k]*V[k][d] [+ half]) >>> FB) with plain integers.
  function automatic exp_t model(input int ow, input int done_edge);
    exp_t   e;
    longint acc, r, hi, lo;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -(longint'(1) << (ow - 1));
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++) begin
        acc = 0;
        for (int k = 0; k < SL; k++) acc += p_m[i][k] * v_m[k][d];
        acc += RND_EXP << (FB - 1);
        r = acc >>> FB;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        e.o[i*HD + d] = r;
      end
    e.done_edge = done_edge;
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < SL; i++)
      for (int k = 0; k < SL; k++) begin
        m_if.scores_flat[(i*SL + k)*SW +: SW] = p_m[i][k][SW-1:0];
        s_if.scores_flat[(i*SL + k)*SW +: SW] = p_m[i][k][SW-1:0];
      end
    for (int k = 0; k < SL; k++)
      for (int d = 0; d < HD; d++) begin
        m_if.v_flat[(k*HD + d)*VW +: VW] = v_m[k][d][VW-1:0];
        s_if.v_flat[(k*HD + d)*VW +: VW] = v_m[k][d][VW-1:0];
      end
  endtask

  task automatic fill(input longint p_val, input longint v_val);
    for (int i = 0; i < SL; i++)
      for (int k = 0; k < SL; k++) p_m[i][k] = p_val;
    for (int k = 0; k < SL; k++)
      for (int d = 0; d < HD; d++) v_m[k][d] = v_val;
  endtask

  // Ranges keep the model's 64-bit sums exact while still reaching the clamp limits.
  task automatic rand_fill(input int mode);
    for (int i = 0; i < SL; i++)
      for (int k = 0; k < SL; k++)
        p_m[i][k] = (mode == 2) ? longint'($urandom()) : longint'($urandom_range(0, 32768));
    for (int k = 0; k < SL; k++)
      for (int d = 0; d < HD; d++)
        case (mode)
          0:       v_m[k][d] = longint'($urandom_range(0, 65535)) - 32768;
          1:       v_m[k][d] = longint'(int'($urandom()));
          default: v_m[k][d] = longint'($urandom_range(0, 512)) - 256;
        endcase
  endtask

  task automatic launch(input bit sat);
    int s;
    drive_inputs();
    @(negedge clk);
    if (sat) s_if.start = 1'b1; else m_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    m_if.start = 1'b0;
    s = cyc;
    if (sat) begin
      q_sat.push_back(model(OWS, s + N + 1));
      check("sat_busy_rise", s_if.busy, 1);
    end else begin
      q_main.push_back(model(OW, s + N + 1));
      check("main_busy_rise", m_if.busy, 1);
    end
  endtask

  task automatic wait_idle(input bit sat);
    int n = 0;
    while ((sat ? s_if.busy : m_if.busy) !== 1'b0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", longint'(n < BOUND), 1);
  endtask

  // Monitors: pop one expected result per done pulse and compare timing and contents.
  logic m_prev = 1'b0;
  logic s_prev = 1'b0;

  always @(negedge clk) begin
    if (m_if.done === 1'b1) begin
      check("main_done_single_pulse", m_prev, 0);
      check("main_queue_nonempty", longint'(q_main.size() > 0), 1);
      if (q_main.size() > 0) begin
        exp_t e;
        e = q_main.pop_front();
        check("main_done_edge", cyc, e.done_edge);
        for (int j = 0; j < NE; j++) check($sformatf("main_out[%0d]", j), m_elem(j), e.o[j]);
      end
    end
    m_prev <= m_if.done;
  end

  always @(negedge clk) begin
    if (s_if.done === 1'b1) begin
      check("sat_done_single_pulse", s_prev, 0);
      check("sat_queue_nonempty", longint'(q_sat.size() > 0), 1);
      if (q_sat.size() > 0) begin
        exp_t e;
        e = q_sat.pop_front();
        check("sat_done_edge", cyc, e.done_edge);
        for (int j = 0; j < NE; j++) check($sformatf("sat_out[%0d]", j), s_elem(j), e.o[j]);
      end
    end
    s_prev <= s_if.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, n;
    rst = 1'b0;
    m_if.start = 1'b0;
    s_if.start = 1'b0;
    fill(0, 0);
    drive_inputs();
    #12;
    check("reset_busy", m_if.busy, 0);
    check("reset_done", m_if.done, 0);
    check("reset_out_zero", longint'(m_if.out_flat == '0), 1);
    @(negedge clk);
    rst = 1'b1;

    // Uniform P = 0.25, V[k][d] = k -> 1.5 everywhere.
    fill(4096, 0);
    for (int k = 0; k < SL; k++)
      for (int d = 0; d < HD; d++) v_m[k][d] = k * 16384;
    launch(0);
    wait_idle(0);
    check("uniform_o00", m_elem(0), 24576);
    check("uniform_o31", m_elem(NE - 1), 24576);

    // Identity P reproduces V exactly, including values beyond +-1.0.
    fill(0, 0);
    for (int i = 0; i < SL; i++) p_m[i][i] = 16384;
    v_m[0][0] = -32768; v_m[0][1] = 49152;
    v_m[1][0] = 12345;  v_m[1][1] = -1;
    v_m[2][0] = 0;      v_m[2][1] = -7000;
    v_m[3][0] = 32767;  v_m[3][1] = -16384;
    launch(0);
    wait_idle(0);
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++)
        check($sformatf("identity_o%0d%0d", i, d), m_elem(i*HD + d), v_m[i][d]);

    // Saturation on the 16-bit instance.
    fill(16384, 32767);
    launch(1);
    wait_idle(1);
    check("sat_pos_o00", s_elem(0), 32767);
    fill(16384, -32768);
    launch(1);
    wait_idle(1);
    check("sat_neg_o00", s_elem(0), -32768);

    // Half-LSB rounding case.
    fill(0, 0);
    p_m[0][0] = 1;
    v_m[0][0] = 8192;
    launch(0);
    wait_idle(0);
    check("round_o00", m_elem(0), RND_EXP);

    // start pulsed mid-run is ignored: no restart, no queued second run.
    fill(4096, 16384);
    launch(0);
    repeat (9) @(negedge clk);
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);
    check("ignored_start_stays_idle", m_if.busy, 0);

    // start held through done -> second run sampled one edge after done.
    rand_fill(0);
    drive_inputs();
    @(negedge clk);
    m_if.start = 1'b1;
    @(negedge clk);
    s = cyc;
    q_main.push_back(model(OW, s + N + 1));
    q_main.push_back(model(OW, s + N + 2 + N + 1));
    n = 0;
    while (m_if.done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done_within_bound", longint'(n < BOUND), 1);
    @(negedge clk);
    m_if.start = 1'b0;
    check("b2b_second_run_busy", m_if.busy, 1);
    wait_idle(0);

    // Reset mid-run clears everything asynchronously; a fresh run then completes.
    rand_fill(1);
    drive_inputs();
    @(negedge clk);
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", m_if.busy, 0);
    check("midrst_done", m_if.done, 0);
    check("midrst_out_zero", longint'(m_if.out_flat == '0), 1);
    check("midrst_sat_out_zero", longint'(s_if.out_flat == '0), 1);
    @(negedge clk);
    rst = 1'b1;
    launch(0);
    wait_idle(0);

    // Randomised runs across the three operand ranges.
    for (int r = 0; r < 6; r++) begin
      rand_fill(r % 3);
      launch(0);
      wait_idle(0);
    end
    for (int r = 0; r < 2; r++) begin
      rand_fill(r);
      launch(1);
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    check("main_queue_drained", q_main.size(), 0);
    check("sat_queue_drained", q_sat.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
